prng_lcg_buf: RTL
=================

# prng_lcg_buf

Parametrised linear-congruential random number generator with a small output FIFO and a valid/ready stream interface. It replaces the single-shot start/valid PRNG. Generation runs in the background while the FIFO has room, so the consumer can pop one reduced random number per cycle while the FIFO holds data. It sits beside the signature datapath and feeds index/sample consumers that need values in [0, RANGE).

## Interface
Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- SEED_W, 32: LCG state width; arithmetic is modulo 2^SEED_W.
- LCG_A, 214013: multiplier constant, at most 18 bits.
- LCG_C, 2531011: increment constant.
- OUT_LSB, 16: lowest state bit taken for the raw output.
- OUT_W, 13: raw/output width. Constraint: OUT_LSB+OUT_W <= SEED_W.
- RANGE, 4900: output modulus. Constraint: RANGE <= 2^OUT_W <= 2*RANGE.
- MUL_LAT, 3: multiplier pipeline latency in cycles, >= 1.
- DEPTH, 4: FIFO depth, a power of 2, >= 2.

Ports:
- clk, in, 1: clock.
- rst_b, in, 1: asynchronous active-low reset.
- cmd, in, 2: 0 = hold, 1 = run, 2 = load seed, 3 = flush.
- seed_dat, in, SEED_W: seed, sampled when cmd==2.
- rnd_valid, out, 1: FIFO non-empty.
- rnd_ready, in, 1: consumer accepts the head entry.
- rnd_dat, out, OUT_W: FIFO head, always < RANGE.
- fifo_cnt, out, clog2(DEPTH)+1: current FIFO occupancy.
- busy, out, 1: high while in CALC.

## Operation
- Registers: state seed_reg[SEED_W], FSM {IDLE, CALC}, cnt counting 0..MUL_LAT-1, and the FIFO.
- Next state: nxt = (LCG_A*seed_reg + LCG_C) mod 2^SEED_W. The product is computed by an internal pipelined multiplier; only the low SEED_W bits are kept.
- Raw output: raw = nxt[OUT_LSB+OUT_W-1:OUT_LSB].
- Reduced output: out = (raw >= RANGE) ? raw-RANGE : raw. A single subtraction is sufficient because of the RANGE constraint.
- IDLE → CALC when cmd==1 and fifo_cnt < DEPTH; cnt is cleared on entry. seed_reg does not change during CALC.
- CALC, cnt==MUL_LAT-1 (commit cycle):
  - seed_reg ← nxt.
  - out is pushed into the FIFO.
  - FSM → IDLE.
- CALC, cnt < MUL_LAT-1: cnt increments.
- The space check in IDLE guarantees the commit never finds the FIFO full; at most one generation is in flight.
- Pop: rnd_valid && rnd_ready removes the head. A push and a pop in the same cycle leaves fifo_cnt unchanged and keeps order.
- cmd==2, any state:
  - seed_reg ← seed_dat.
  - The FIFO is emptied.
  - Any in-flight CALC is aborted with no push; FSM → IDLE.
- cmd==3, any state: empties the FIFO and aborts CALC with no push. seed_reg is kept, so the sequence continues from the last committed state.
- cmd==0 or cmd≠1 during CALC: the current generation completes and pushes; no new generation starts.
- Pop during cmd 2/3: the flush wins and the pop is discarded.

## Timing
- Reset values:
  - seed_reg=0, FSM=IDLE, cnt=0.
  - FIFO empty, fifo_cnt=0.
  - rnd_valid=0, rnd_dat=0, busy=0.
- Latency: the first entry is visible (rnd_valid=1) MUL_LAT+1 cycles after the first cycle cmd==1 is sampled in IDLE with an empty FIFO.
- Sustained fill rate: one entry per MUL_LAT+1 cycles (the commit cycle plus the IDLE re-check).
- rnd_dat and rnd_valid are registered FIFO outputs. rnd_dat is held stable while rnd_valid=1 and rnd_ready=0.
- When the FIFO is full, generation stalls in IDLE. The cycle after a pop frees a slot, IDLE re-evaluates and starts CALC if cmd==1.
- fifo_cnt reflects pushes and pops of the previous edge.
- Asynchronous reset mid-CALC discards all state immediately with no partial push.

## Test plan
- Seed 1: reset, cmd=2 with seed_dat=1, then cmd=1, rnd_ready=1. Required rnd_dat sequence begins 41, 2083, and matches the golden model (MSVC rand() bits [28:16], reduced mod 4900). First rnd_valid appears MUL_LAT+1 cycles after run.
- Seed 0: cmd=2 with seed 0, one generation. Required rnd_dat=38 and seed_reg=2531011.
- Backpressure: rnd_ready=0 with cmd=1. Required: fifo_cnt saturates at 4, busy stays 0 afterwards, and rnd_dat holds stable. Releasing rnd_ready drains the entries in order with no loss or duplication against the model.
- Reseed mid-CALC: cmd=2 in cycle 1 of CALC with seed 5. Required: no stale push, FIFO empty, and the next output equals the model of seed 5.
- Flush: cmd=3 with 3 entries queued. Required: fifo_cnt=0 on the next edge, and resumed outputs continue the sequence from the last committed seed.
- Reduction and range: force seed values giving raw ≥ 4900 (e.g. raw=8191 → 3291, raw=4900 → 0). Over 100k random outputs, assert all outputs < 4900 and that they match the model.

Source files
------------

// File: rtl/prng_lcg_buf.sv
// LCG random source with a pipelined multiplier, single-step range reduction
// and a small shift-register FIFO behind a valid/ready stream.
module prng_lcg_buf #(
    parameter int unsigned SEED_W  = 32,
    parameter int unsigned LCG_A   = 214013,
    parameter int unsigned LCG_C   = 2531011,
    parameter int unsigned OUT_LSB = 16,
    parameter int unsigned OUT_W   = 13,
    parameter int unsigned RANGE   = 4900,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic [1:0]             cmd,
    input  logic [SEED_W-1:0]      seed_dat,
    output logic                   rnd_valid,
    input  logic                   rnd_ready,
    output logic [OUT_W-1:0]       rnd_dat,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                   busy
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned FC_W  = PTR_W + 1;
    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;

    localparam logic [1:0] CMD_RUN   = 2'd1;
    localparam logic [1:0] CMD_LOAD  = 2'd2;
    localparam logic [1:0] CMD_FLUSH = 2'd3;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEED_W-1:0] seed_q, seed_d;
    logic [SEED_W-1:0] mul_pipe [MUL_LAT];
    logic [SEED_W-1:0] nxt;
    logic [OUT_W-1:0]  raw, red;
    logic              push, flush, pop;
    logic [OUT_W-1:0]  mem_q [DEPTH];
    logic [OUT_W-1:0]  mem_d [DEPTH];
    logic [FC_W-1:0]   fcnt_d, cnt_after_pop;

    // Free-running multiplier chain; seed_q is stable for the whole CALC window
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] <= '0;
        end else begin
            mul_pipe[0] <= SEED_W'(LCG_A) * seed_q;
            for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
        end
    end

    // RANGE <= 2^OUT_W <= 2*RANGE keeps one conditional subtraction exact
    assign nxt = mul_pipe[MUL_LAT-1] + SEED_W'(LCG_C);
    assign raw = nxt[OUT_LSB +: OUT_W];
    assign red = (raw >= OUT_W'(RANGE)) ? raw - OUT_W'(RANGE) : raw;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seed_q  <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            busy    <= (state_d == CALC);
        end
    end

    // Load/flush override everything; otherwise one generation at a time
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (cmd == CMD_LOAD) begin
            seed_d  = seed_dat;
            flush   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (cmd == CMD_FLUSH) begin
            flush   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd == CMD_RUN && fifo_cnt < FC_W'(DEPTH)) begin
                        state_d = CALC;
                        cnt_d   = '0;
                    end
                end
                CALC: begin
                    if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
                        seed_d  = nxt;
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign pop = rnd_valid & rnd_ready;

    // Head lives in mem_q[0] so rnd_dat comes straight from a flop
    always_comb begin
        mem_d         = mem_q;
        fcnt_d        = fifo_cnt;
        cnt_after_pop = fifo_cnt;
        if (flush) begin
            fcnt_d = '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
                cnt_after_pop = fifo_cnt - FC_W'(1);
            end
            if (push) mem_d[PTR_W'(cnt_after_pop)] = red;
            fcnt_d = cnt_after_pop + FC_W'(push);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            fifo_cnt  <= '0;
            rnd_valid <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            fifo_cnt  <= fcnt_d;
            rnd_valid <= (fcnt_d != '0);
        end
    end

    assign rnd_dat = mem_q[0];

endmodule
